// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor_if: operand/handshake/result bundle for the         |
// | bit-serial subtractor. Bin exists only with SUB_BORROW_IN_EN.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SUB_BORROW_IN_EN
    logic             Bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
    logic             Ovf;

    modport master (
        output start, A, B,
`ifdef SUB_BORROW_IN_EN
        output Bin,
`endif
        input  busy, done, Diff, Bout, Zero, Ovf
    );

    modport slave (
        input  start, A, B,
`ifdef SUB_BORROW_IN_EN
        input  Bin,
`endif
        output busy, done, Diff, Bout, Zero, Ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor: LSB-first bit-serial A - B (- Bin) with start/busy/|
// | done handshake; optional borrow-in under macro SUB_BORROW_IN_EN.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sr_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, zero_q, ovf_q;

    logic             busy_o, done_o;
    logic             d_bit, br_next, last_bit, seed_br;
    logic [WIDTH-1:0] sr_next;

    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign sr_next  = (sr_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last_bit = (cnt_q == LAST_CNT);

`ifdef SUB_BORROW_IN_EN
    assign seed_br = bus.Bin;
`else
    assign seed_br = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CALC;
            S_CALC:  if (last_bit)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_CALC:  busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sr_q   <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                a_q   <= bus.A;
                b_q   <= bus.B;
                br_q  <= seed_br;
                cnt_q <= '0;
            end else if (state_q == S_CALC) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                br_q  <= br_next;
                sr_q  <= sr_next;
                cnt_q <= cnt_q + CNT_W'(1);
                // On the final bit the operand LSBs are the original MSBs.
                if (last_bit) begin
                    diff_q <= sr_next;
                    bout_q <= br_next;
                    zero_q <= (sr_next == '0);
                    ovf_q  <= (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
                end
            end
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Zero = zero_q;
    assign bus.Ovf  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor: scoreboard bench for serial_subtractor.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
    serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    res_t m_exp, m_act;
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    function automatic res_t mk(input logic [WIDTH-1:0] d, input logic bo, input logic z, input logic ov);
        mk = '{diff: d, bout: bo, zero: z, ovf: ov};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_exp = exp_q.pop_front();
                m_act = '{diff: bus.Diff, bout: bus.Bout, zero: bus.Zero, ovf: bus.Ovf};
                checks++;
                if (m_act !== m_exp) begin
                    failures++;
                    $display("FAIL result: got Diff=%h Bout=%b Zero=%b Ovf=%b expected Diff=%h Bout=%b Zero=%b Ovf=%b",
                             m_act.diff, m_act.bout, m_act.zero, m_act.ovf,
                             m_exp.diff, m_exp.bout, m_exp.zero, m_exp.ovf);
                end
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input res_t e, input int pulse_at);
        int n;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        exp_q.push_back(e);
        n = 0; busy_cnt = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.A     = 8'hA5;
                bus.B     = 8'h5A;
            end
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.A     = 8'hFF;
            end
            if (pulse_at > 0 && n == pulse_at + 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) seen = 1;
        end
        check("latency", n, 9);
        check("busy_cycles", busy_cnt, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
`ifdef SUB_BORROW_IN_EN
        bus.Bin = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_flags", {bus.Diff, bus.Bout, bus.Zero, bus.Ovf}, 0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0, 1'b0), 0);
        run_op(8'h03, 8'h05, mk(8'hFE, 1'b1, 1'b0, 1'b0), 0);
        run_op(8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b0, 1'b1), 0);
        run_op(8'h42, 8'h42, mk(8'h00, 1'b0, 1'b1, 1'b0), 0);
        repeat (5) begin
            @(negedge clk);
            check("hold_done", bus.done, 0);
            check("hold_result", {bus.Diff, bus.Zero}, {8'h00, 1'b1});
        end

        // Start pulse mid-CALC must be dropped; then a back-to-back issue.
        run_op(8'h10, 8'h01, mk(8'h0F, 1'b0, 1'b0, 1'b0), 3);
        run_op(8'h01, 8'h02, mk(8'hFF, 1'b1, 1'b0, 1'b0), 0);
        run_op(8'h7F, 8'hFF, mk(8'h80, 1'b1, 1'b0, 1'b1), 0);

        @(negedge clk);
        bus.A = 8'h20; bus.B = 8'h01; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_flags", {bus.Diff, bus.Bout, bus.Zero, bus.Ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        check("no_done_after_abort", cnt, 0);
        run_op(8'h20, 8'h01, mk(8'h1F, 1'b0, 1'b0, 1'b0), 0);

`ifdef SUB_BORROW_IN_EN
        bus.Bin = 1'b1;
        run_op(8'h10, 8'h01, mk(8'h0E, 1'b0, 1'b0, 1'b0), 0);
        run_op(8'h00, 8'h00, mk(8'hFF, 1'b1, 1'b0, 1'b0), 0);
        bus.Bin = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle 8-bit subtractor for the 8086 datapath ALU: computes Diff = A - B (optionally - Bin), one bit per clock, LSB first.
- Inverse counterpart of the combinational ripple adder. Shares that adder's A/B operand interface and feeds SUB/CMP/SBB flag generation.
- start/busy/done handshake. Result and flags are registered and held until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on accepted start
- B  input  WIDTH  subtrahend; captured on accepted start
- Bin  input  1  borrow-in; present only with SUB_BORROW_IN_EN
- busy  output  1  high while an operation is in progress (CALC)
- done  output  1  one-cycle pulse when the result is valid
- Diff  output  WIDTH  registered difference
- Bout  output  1  borrow-out (unsigned A < B, including borrow-in)
- Zero  output  1  Diff == 0
- Ovf  output  1  signed overflow: A[MSB] != B[MSB] and Diff[MSB] != A[MSB]

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy = 0, done = 0, Diff = 0, Bout = 0, Zero = 0, Ovf = 0; internal shift registers, borrow flop and bit counter cleared.
- State machine IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - start = 1 at edge k: capture A and B into shift registers, initialise the borrow flop (0, or Bin with the feature), clear the counter, go to CALC.
  - start = 0: remain in IDLE; outputs hold their last values.
- CALC (busy = 1): each edge processes the LSBs a, b and borrow br of the shift registers:
  - d = a ^ b ^ br
  - br' = (~a & b) | (~(a ^ b) & br)
  - d shifts into the Diff shift register at the MSB end; A and B shift right; counter increments.
  - After WIDTH edges (edges k+1 .. k+WIDTH), go to DONE.
  - Diff/Bout/Zero/Ovf outputs are not updated during CALC; they hold the previous result.
- DONE:
  - Outputs update on the transition into DONE: Diff from the shift register, Bout = final borrow, Zero = (Diff == 0), Ovf computed from the captured operand MSBs.
  - done = 1 for exactly one cycle (the cycle after edge k+WIDTH); busy = 0.
  - Next edge returns to IDLE.
- Latency: start sampled at edge k -> done high during the cycle following edge k+WIDTH (WIDTH+1 edges; 9 for WIDTH = 8).
- start while busy or in DONE: ignored; it is neither queued nor re-sampled later.
- Back-to-back operation: start asserted in the IDLE cycle immediately after DONE is accepted. Minimum issue interval is WIDTH+2 cycles.
- A/B may change after the capture edge without affecting the operation in flight.
- Reset asserted mid-CALC: the operation is aborted and all outputs clear immediately. After reset deasserts, no done pulse is issued for the aborted operation.
- Width rule: all arithmetic is modulo 2^WIDTH; Bout carries the unsigned borrow.

Optional Feature:
- Macro SUB_BORROW_IN_EN.
- Defined: the Bin port exists and is captured with A/B on start. It seeds the borrow flop, giving Diff = A - B - Bin (8086 SBB and multi-byte chaining). Bout and Ovf include the effect of Bin.
- Undefined: the Bin port is absent and the borrow flop seeds to 0 (plain SUB/CMP).

Test Plan:
- A = 0x05, B = 0x03, start for one cycle -> busy for 8 cycles; done one cycle later (9 edges after start); Diff = 0x02, Bout = 0, Zero = 0, Ovf = 0.
- A = 0x03, B = 0x05 -> Diff = 0xFE, Bout = 1, Ovf = 0; A = 0x80, B = 0x01 -> Diff = 0x7F, Bout = 0, Ovf = 1.
- A = 0x42, B = 0x42 -> Diff = 0x00, Zero = 1, Bout = 0; afterwards idle with start = 0 for 5 cycles -> outputs hold and done stays 0.
- Start 0x10 - 0x01, pulse start again at cycle 3 with A = 0xFF -> second start ignored; single done; Diff = 0x0F. Back-to-back start in the cycle after DONE -> second result 9 edges later.
- Start 0x20 - 0x01, assert rst at cycle 4 -> all outputs 0 immediately; no done after release; a new start of 0x20 - 0x01 then yields Diff = 0x1F.
- With SUB_BORROW_IN_EN: A = 0x10, B = 0x01, Bin = 1 -> Diff = 0x0E, Bout = 0; A = 0x00, B = 0x00, Bin = 1 -> Diff = 0xFF, Bout = 1.
